// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-back stage.
package regfile_pkg;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WR_COUNT_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // Storage-side select mask: x0 is never allowed to load.
    localparam logic [REG_COUNT-1:0] STORE_MASK = {{(REG_COUNT-1){1'b1}}, 1'b0};

    // True when a write request targets a real (non-x0) register.
    function automatic logic is_real_write(input logic ena, input reg_addr_t addr);
        return ena && (addr != REG_ZERO);
    endfunction

endpackage : regfile_pkg

// File: rtl/decoder5to32.sv
// 5-to-32 one-hot write-select decoder; all zeros when not enabled.
module decoder5to32
    import regfile_pkg::*;
(
    input  logic                 ena,
    input  reg_addr_t            addr,
    output logic [REG_COUNT-1:0] sel
);

    // One-hot select of the addressed register, or nothing.
    always_comb begin
        sel = '0;
        if (ena) begin
            sel = REG_COUNT'(1) << addr;
        end
    end

endmodule : decoder5to32

// File: rtl/mux32.sv
// 32-way read multiplexer over the register outputs.
module mux32
    import regfile_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [REG_COUNT-1:0][N-1:0] din,
    input  reg_addr_t                   sel,
    output logic [N-1:0]                dout
);

    // Select one of the 32 inputs.
    always_comb begin
        dout = din[sel];
    end

endmodule : mux32

// File: rtl/regfile_write_demux.sv
// 32 x N register file: one-hot write demux, two mux32 read ports,
// same-cycle write bypass, x0 hardwired to zero, saturating write counter.
module regfile_write_demux
    import regfile_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_ena,
    input  reg_addr_t             wr_addr,
    input  logic [N-1:0]          wr_data,
    input  reg_addr_t             rd_addr0,
    input  reg_addr_t             rd_addr1,
    output logic [N-1:0]          rd_data0,
    output logic [N-1:0]          rd_data1,
    output logic [WR_COUNT_W-1:0] wr_count
);

    logic [REG_COUNT-1:0]        wr_sel;
    logic [REG_COUNT-1:0]        store_sel;
    logic [REG_COUNT-1:0][N-1:0] reg_bus;
    logic [N-1:0]                mux_out0;
    logic [N-1:0]                mux_out1;
    logic                        commit;
    logic                        bypass0;
    logic                        bypass1;
    logic [WR_COUNT_W-1:0]       wr_count_q;
    logic [WR_COUNT_W-1:0]       wr_count_d;

    decoder5to32 u_decoder (
        .ena  (wr_ena),
        .addr (wr_addr),
        .sel  (wr_sel)
    );

    // Mask x0 before the storage and derive the commit strobe.
    always_comb begin
        store_sel = wr_sel & STORE_MASK;
        commit    = |store_sel;
    end

    // x0 is a constant-zero mux input rather than a flop.
    assign reg_bus[0] = '0;

    for (genvar k = 1; k < REG_COUNT; k++) begin : g_reg
        logic [N-1:0] reg_q;
        logic [N-1:0] reg_d;

        // Load write data when selected, otherwise hold.
        always_comb begin
            reg_d = reg_q;
            if (store_sel[k]) begin
                reg_d = wr_data;
            end
        end

        // Register storage; reset wins over a simultaneous write.
        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign reg_bus[k] = reg_q;
    end

    mux32 #(.N(N)) u_rd_mux0 (
        .din  (reg_bus),
        .sel  (rd_addr0),
        .dout (mux_out0)
    );

    mux32 #(.N(N)) u_rd_mux1 (
        .din  (reg_bus),
        .sel  (rd_addr1),
        .dout (mux_out1)
    );

    // Per-port bypass of a same-cycle write; suppressed during reset.
    always_comb begin
        bypass0  = !rst && is_real_write(wr_ena, wr_addr) && (rd_addr0 == wr_addr);
        bypass1  = !rst && is_real_write(wr_ena, wr_addr) && (rd_addr1 == wr_addr);
        rd_data0 = bypass0 ? wr_data : mux_out0;
        rd_data1 = bypass1 ? wr_data : mux_out1;
    end

    // Saturating count of committed non-x0 writes.
    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + WR_COUNT_W'(1);
        end
    end

    // Write counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

endmodule : regfile_write_demux

// File: tb/tb_regfile_write_demux.sv
// Self-checking bench for regfile_write_demux: directed plan plus random traffic
// against an array-based behavioural model.
module tb_regfile_write_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic [31:0] wr_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl_mem [32];
    logic [31:0] mdl_cnt   = 32'd0;
    bit          mdl_valid = 1'b0;

    always #5 clk = ~clk;

    regfile_write_demux #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .wr_count (wr_count)
    );

    // Model: what a read port must show this cycle.
    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        if (!rst && wr_ena && wr_addr != 5'd0 && a == wr_addr) return wr_data;
        if (a == 5'd0) return 32'd0;
        return mdl_mem[a];
    endfunction

    // Model state update at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl_mem[i] = 32'd0;
            mdl_cnt   = 32'd0;
            mdl_valid = 1'b1;
        end else if (wr_ena && wr_addr != 5'd0) begin
            mdl_mem[wr_addr] = wr_data;
            if (mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model for the current cycle.
    task automatic cmp_model();
        if (mdl_valid) begin
            chk("model_rd0", rd_data0, mdl_read(rd_addr0));
            chk("model_rd1", rd_data1, mdl_read(rd_addr1));
            chk("model_cnt", wr_count, mdl_cnt);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then compare.
    task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clk);
        rst      = r;
        wr_ena   = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr0 = ra0;
        rd_addr1 = ra1;
        #1;
        cmp_model();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl_mem[i] = 32'd0;
        rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;

        // Reset then read all registers.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            chk("reset_read", rd_data0, 32'd0);
        end
        chk("reset_count", wr_count, 32'd0);

        // Write and read back.
        cycle(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0);
        cycle(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0,  32'd0,        5'd5, 5'd31);
        chk("wb_x5",    rd_data0, 32'hDEADBEEF);
        chk("wb_x31",   rd_data1, 32'h12345678);
        chk("wb_count", wr_count, 32'd2);

        // x0 immunity, including no bypass to x0.
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk("x0_bypass", rd_data0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
        chk("x0_read",  rd_data0, 32'd0);
        chk("x0_other", rd_data1, 32'hDEADBEEF);
        chk("x0_count", wr_count, 32'd2);

        // Same-cycle bypass on both ports, then port 1 on x0.
        cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        chk("byp_both0", rd_data0, 32'hA5A5A5A5);
        chk("byp_both1", rd_data1, 32'hA5A5A5A5);
        cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0);
        chk("byp_p0",    rd_data0, 32'hA5A5A5A5);
        chk("byp_p1_x0", rd_data1, 32'd0);

        // Back-to-back writes to one index: last wins.
        cycle(1'b0, 1'b1, 5'd9, 32'h1, 5'd0, 5'd0);
        cycle(1'b0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd0);
        chk("b2b_byp", rd_data0, 32'h2);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        chk("b2b_last", rd_data0, 32'h2);

        // Reset priority over a simultaneous write; bypass suppressed in reset.
        cycle(1'b0, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
        cycle(1'b1, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
        chk("rstpri_nobyp", rd_data0, 32'h11);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5);
        chk("rstpri_x3",    rd_data0, 32'd0);
        chk("rstpri_x5",    rd_data1, 32'd0);
        chk("rstpri_count", wr_count, 32'd0);

        // Decoder exhaustive: xk <= k+1.
        for (int k = 1; k < 32; k++) begin
            cycle(1'b0, 1'b1, 5'(k), 32'(k + 1), 5'(k), 5'd0);
        end
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(k), 5'd0);
            chk("dec_read", rd_data0, (k == 0) ? 32'd0 : 32'(k + 1));
        end
        chk("dec_count", wr_count, 32'd31);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_write_demux

// File: doc/regfile_write_demux.md
# regfile_write_demux

Write-side counterpart to the 32-way read mux: a 32-entry × N-bit register file whose write path is a 5-to-32 one-hot decoder (demux) steering write data into exactly one register per cycle. It sits in the CPU write-back stage. The two read ports are built from two `mux32` instances selecting among the 32 register outputs. A bypass path lets a same-cycle write be visible on the read ports.

## Interface
- `N`, default 32: data width of each register and of the read/write data ports.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset; sampled on rising edge of `clk`.
- `wr_ena` input 1: write request for this cycle.
- `wr_addr` input 5: destination register index.
- `wr_data` input N: data to write.
- `rd_addr0` input 5: read port 0 index.
- `rd_addr1` input 5: read port 1 index.
- `rd_data0` output N: read port 0 data, combinational.
- `rd_data1` output N: read port 1 data, combinational.
- `wr_count` output 32: number of committed (non-x0) writes since reset; saturates at 2^32−1.

## Operation
- The decoder produces `wr_sel[31:0]`. When `wr_ena`=1, `wr_sel` = 1 << `wr_addr`; otherwise it is all zeros. At most one bit is ever set.
- Register k loads `wr_data` on the rising edge when `wr_sel[k]`=1 and `rst`=0. All other registers hold their value.
- x0 is hardwired to zero:
  - Register 0 is never written.
  - `wr_sel[0]` is masked before reaching the storage.
  - Reads of index 0 always return 0.
- Reads use two `mux32` instances (selects `rd_addr0`/`rd_addr1`) over the 32 register outputs.
- Bypass applies when `wr_ena`=1, `wr_addr`≠0 and `rd_addrX`==`wr_addr`. In that case `rd_dataX` = `wr_data` in the same cycle; otherwise it is the mux output. The bypass applies to each port independently, and to both ports together when both match.
- `wr_count` increments by 1 on each edge where a non-x0 write commits and `rst`=0. It holds at 0xFFFF_FFFF once reached.
- Reset (`rst`=1 at an edge) clears every register and `wr_count` to 0. Reset has priority over a simultaneous write, so that write is dropped and not counted.
- Reset asserted mid-operation has the same effect; no partial state survives.
- While `rst`=1, the read ports still show register contents combinationally, but no writes commit. Bypass is suppressed while `rst`=1.

## Timing
- Write latency: 1 cycle. Data written at edge t is visible through storage from t+ onward, and through the bypass during cycle t itself.
- Read latency: 0 cycles (combinational from `rd_addr*`, storage, `wr_*`).
- Back-to-back writes to the same index are allowed every cycle; the last write wins.
- Reset values after any reset edge: all registers 0, `wr_count` 0. `rd_data0`/`rd_data1` are 0 until written, unless bypassed.
- No handshake: every `wr_ena` cycle is accepted and there is no back-pressure.

## Structure
- Shared package `regfile_pkg`:
  - `REG_COUNT` = 32.
  - `REG_ADDR_W` = 5.
  - `REG_ZERO` = 5'd0.
  - Typedef `reg_addr_t` (logic [4:0]).
- Sub-module `decoder5to32`: inputs `ena` (1 bit) and `addr` (5 bits); output `sel` [31:0]. Purely combinational, one-hot or zero.
- Storage: 31 N-bit registers in a generate loop (indices 1..31). Index 0 is a constant-zero input to the muxes.
- Reuse the existing `mux32` for both read ports.

## Test plan
- Reset then read all: assert `rst` 1 cycle, sweep `rd_addr0` 0..31 → every read returns 0 and `wr_count`=0.
- Write/readback: write 0xDEADBEEF to x5, then 0x12345678 to x31. Read x5 on port 0 and x31 on port 1 the next cycle → 0xDEADBEEF and 0x12345678; `wr_count`=2.
- x0 immunity: write 0xFFFFFFFF to x0 → reads of x0 return 0, `wr_count` unchanged, no other register modified.
- Bypass: in the same cycle, write 0xA5A5A5A5 to x7 with `rd_addr0`=`rd_addr1`=7 → both ports show 0xA5A5A5A5 that cycle. With `rd_addr1`=0 instead → port 1 shows 0.
- Reset priority: x3=0x11 held; assert `rst` together with a write of 0x22 to x3 → next cycle x3 reads 0 and `wr_count`=0.
- Decoder exhaustive: write value k+1 to each xk for k=1..31 on consecutive cycles → each xk reads k+1, x0 reads 0, `wr_count`=31.
